// File: rtl/apu_pkg.sv
// apu_pkg
// Shared definitions for the APU host register writer:
//   - register offsets (relative to $4000) of the registers held locally
//   - the marker carried in bits 7:5 of an address byte
//   - the two-state framing enum used by the byte decoder
package apu_pkg;

  localparam logic [4:0] OFS_400C = 5'h0C;
  localparam logic [4:0] OFS_400E = 5'h0E;
  localparam logic [4:0] OFS_400F = 5'h0F;
  localparam logic [4:0] OFS_4015 = 5'h15;

  // Address bytes are 1_00_ooooo; the top three bits identify them.
  localparam logic [2:0] ADDR_MARK = 3'b100;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

endpackage

// File: rtl/apu_rx_timeout.sv
// apu_rx_timeout
// Idle counter that measures how long the decoder has waited for a data byte.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   i_clear     - restart the count at zero (address byte accepted)
//   i_enable    - one more idle cycle has elapsed
//   o_expire    - the count has reached TIMEOUT_CYCLES
// TIMEOUT_CYCLES must be at least 2.
module apu_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == LIMIT);
  assign o_expire   = w_at_limit;

  // The count parks at the limit so it can never wrap back to a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/apu_reg_writer.sv
// apu_reg_writer
// Decodes a UART byte stream of (address byte, data byte) pairs into APU
// register writes. Holds the noise registers $400C/$400E/$400F and the
// status register $4015, and broadcasts every write on a generic bus.
// Ports:
//   clk, rst_n            - clock and asynchronous active-low reset
//   rx_data, rx_valid     - received byte and its one-cycle valid strobe
//   reg_400C..reg_4015    - locally held register contents
//   reg_event             - one-cycle pulse on every $400F write
//   write_strobe          - one-cycle pulse on every accepted write
//   write_addr/write_data - offset and data of the most recent write
//   err_count             - saturating count of protocol errors
module apu_reg_writer
  import apu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] reg_400C,
  output logic [7:0] reg_400E,
  output logic [7:0] reg_400F,
  output logic [7:0] reg_4015,
  output logic       reg_event,
  output logic       write_strobe,
  output logic [4:0] write_addr,
  output logic [7:0] write_data,
  output logic [7:0] err_count
);

  state_t     r_state;
  state_t     w_next_state;
  logic [4:0] r_ofs;
  logic [7:0] r_400C, r_400E, r_400F, r_4015;
  logic       r_event, r_strobe;
  logic [4:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_err;

  logic w_accept_addr;
  logic w_write;
  logic w_err;
  logic w_tmo_enable;
  logic w_expire;

  apu_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept_addr),
    .i_enable(w_tmo_enable),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A data byte is checked before the timeout, so a byte that arrives on the
  // very cycle the wait expires still completes the write. While waiting for
  // data every byte is data: only the timeout can restore framing.
  always_comb begin
    w_next_state  = r_state;
    w_accept_addr = 1'b0;
    w_write       = 1'b0;
    w_err         = 1'b0;
    w_tmo_enable  = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data[7:5] == ADDR_MARK) begin
            w_accept_addr = 1'b1;
            w_next_state  = WAIT_DATA;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        if (rx_valid) begin
          w_write      = 1'b1;
          w_next_state = IDLE;
        end else if (w_expire) begin
          w_err        = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_tmo_enable = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Register bank, write bus and error counter. The strobes default low so
  // they last exactly one cycle; reg_event and the new $400F value land on
  // the same edge so a consumer sees both together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ofs    <= '0;
      r_400C   <= '0;
      r_400E   <= '0;
      r_400F   <= '0;
      r_4015   <= '0;
      r_event  <= 1'b0;
      r_strobe <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_err    <= '0;
    end else begin
      r_event  <= 1'b0;
      r_strobe <= 1'b0;
      if (w_accept_addr) begin
        r_ofs <= rx_data[4:0];
      end
      if (w_write) begin
        r_strobe <= 1'b1;
        r_addr   <= r_ofs;
        r_data   <= rx_data;
        case (r_ofs)
          OFS_400C: r_400C <= rx_data;
          OFS_400E: r_400E <= rx_data;
          OFS_400F: begin
            r_400F  <= rx_data;
            r_event <= 1'b1;
          end
          OFS_4015: r_4015 <= rx_data;
          default: ;
        endcase
      end
      if (w_err && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

  assign reg_400C     = r_400C;
  assign reg_400E     = r_400E;
  assign reg_400F     = r_400F;
  assign reg_4015     = r_4015;
  assign reg_event    = r_event;
  assign write_strobe = r_strobe;
  assign write_addr   = r_addr;
  assign write_data   = r_data;
  assign err_count    = r_err;

endmodule

// File: tb/tb_apu_reg_writer.sv
// tb_apu_reg_writer
// Directed bench for apu_reg_writer with a transaction-level reference model
// compared against the outputs every cycle, plus literal spot checks.
module tb_apu_reg_writer;

  localparam int T = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] reg_400C, reg_400E, reg_400F, reg_4015;
  logic       reg_event, write_strobe;
  logic [4:0] write_addr;
  logic [7:0] write_data;
  logic [7:0] err_count;

  int nVec  = 0;
  int nFail = 0;

  // Reference model state.
  int  mCyc = 0;
  bit  mPending = 0;
  int  mOfs = 0;
  int  mAddrCyc = 0;
  int  m400C = 0, m400E = 0, m400F = 0, m4015 = 0;
  int  mAddr = 0, mData = 0, mErr = 0;
  bit  mStrobe = 0, mEvent = 0;

  int  dutStrobes = 0;
  int  dutEvents = 0;

  apu_reg_writer #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .reg_400C    (reg_400C),
    .reg_400E    (reg_400E),
    .reg_400F    (reg_400F),
    .reg_4015    (reg_4015),
    .reg_event   (reg_event),
    .write_strobe(write_strobe),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a pending address becomes a write when the next byte arrives,
  // or is abandoned once T whole idle cycles have passed since it arrived.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPending = 0; mOfs = 0; mAddrCyc = 0;
      m400C = 0; m400E = 0; m400F = 0; m4015 = 0;
      mAddr = 0; mData = 0; mErr = 0; mStrobe = 0; mEvent = 0;
    end else begin
      mCyc++;
      mStrobe = 0;
      mEvent  = 0;
      if (rx_valid) begin
        if (mPending) begin
          mPending = 0;
          mAddr = mOfs; mData = rx_data; mStrobe = 1;
          if (mOfs == 'h0C) m400C = rx_data;
          if (mOfs == 'h0E) m400E = rx_data;
          if (mOfs == 'h0F) begin m400F = rx_data; mEvent = 1; end
          if (mOfs == 'h15) m4015 = rx_data;
        end else if (rx_data >= 'h80 && rx_data <= 'h9F) begin
          mPending = 1; mOfs = rx_data - 'h80; mAddrCyc = mCyc;
        end else begin
          mErr = (mErr >= 255) ? 255 : mErr + 1;
        end
      end else if (mPending && (mCyc - mAddrCyc - 1) == T) begin
        mPending = 0;
        mErr = (mErr >= 255) ? 255 : mErr + 1;
      end
    end
  end

  // Every-cycle comparison, half a period after the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_strobe) dutStrobes++;
      if (reg_event) dutEvents++;
      checkOutput("reg_400C", reg_400C, m400C);
      checkOutput("reg_400E", reg_400E, m400E);
      checkOutput("reg_400F", reg_400F, m400F);
      checkOutput("reg_4015", reg_4015, m4015);
      checkOutput("reg_event", reg_event, mEvent);
      checkOutput("write_strobe", write_strobe, mStrobe);
      checkOutput("write_addr", write_addr, mAddr);
      checkOutput("write_data", write_data, mData);
      checkOutput("err_count", err_count, mErr);
    end
  end

  // Called at a falling edge; presents one byte for one cycle and returns
  // at the next falling edge, so outputs of that byte are visible on return.
  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int s0, e0;

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset reg_400F", reg_400F, 0);
    checkOutput("reset write_strobe", write_strobe, 0);
    checkOutput("reset err_count", err_count, 0);

    // $400F write: event and strobe together, for one cycle only.
    applyStimulus(8'h8F);
    applyStimulus(8'h5A);
    checkOutput("t1 reg_400F", reg_400F, 'h5A);
    checkOutput("t1 reg_event", reg_event, 1);
    checkOutput("t1 write_strobe", write_strobe, 1);
    checkOutput("t1 write_addr", write_addr, 'h0F);
    checkOutput("t1 write_data", write_data, 'h5A);
    idle(1);
    checkOutput("t1 reg_event low", reg_event, 0);
    checkOutput("t1 strobe low", write_strobe, 0);
    // Identical rewrite still pulses the event.
    e0 = dutEvents;
    applyStimulus(8'h8F);
    applyStimulus(8'h5A);
    idle(1);
    checkOutput("t1 rewrite events", dutEvents - e0, 1);

    // Back-to-back $400C / $400E writes.
    resetDut();
    s0 = dutStrobes; e0 = dutEvents;
    applyStimulus(8'h8C);
    applyStimulus(8'h3F);
    applyStimulus(8'h8E);
    applyStimulus(8'h85);
    idle(2);
    checkOutput("t2 reg_400C", reg_400C, 'h3F);
    checkOutput("t2 reg_400E", reg_400E, 'h85);
    checkOutput("t2 strobes", dutStrobes - s0, 2);
    checkOutput("t2 events", dutEvents - e0, 0);

    // Generic-bus-only offset, then a $4015 write.
    resetDut();
    applyStimulus(8'h81);
    applyStimulus(8'hFF);
    checkOutput("t3 write_addr", write_addr, 'h01);
    checkOutput("t3 write_data", write_data, 'hFF);
    checkOutput("t3 reg_400F", reg_400F, 0);
    checkOutput("t3 err_count", err_count, 0);
    applyStimulus(8'h95);
    applyStimulus(8'h1F);
    checkOutput("t3 reg_4015", reg_4015, 'h1F);

    // Rejected bytes in IDLE.
    resetDut();
    s0 = dutStrobes;
    applyStimulus(8'h12);
    applyStimulus(8'hA0);
    idle(1);
    checkOutput("t4 err_count", err_count, 2);
    checkOutput("t4 strobes", dutStrobes - s0, 0);

    // Timeout after T idle cycles; following non-address byte rejected.
    resetDut();
    applyStimulus(8'h8F);
    idle(T);
    checkOutput("t5 no err yet", err_count, 0);
    idle(1);
    checkOutput("t5 timeout err", err_count, 1);
    applyStimulus(8'h77);
    checkOutput("t5 err after 77", err_count, 2);
    checkOutput("t5 reg_400F", reg_400F, 0);

    // Data on the expiry cycle: the write wins.
    resetDut();
    applyStimulus(8'h8C);
    idle(T);
    applyStimulus(8'h11);
    checkOutput("t5b reg_400C", reg_400C, 'h11);
    checkOutput("t5b err_count", err_count, 0);

    // Reset mid-wait discards the address.
    resetDut();
    applyStimulus(8'h8F);
    idle(2);
    resetDut();
    applyStimulus(8'h42);
    idle(1);
    checkOutput("t6 err_count", err_count, 1);
    checkOutput("t6 reg_400F", reg_400F, 0);
    checkOutput("t6 write_data", write_data, 0);

    // Error counter saturation.
    resetDut();
    for (int i = 0; i < 260; i++) applyStimulus(8'h00);
    idle(1);
    checkOutput("t7 err saturate", err_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
